// File: rtl/fc_layer_engine_if.sv
// Bus bundle for fc_layer_engine: pass control, activation/weight read ports,
// output-buffer write port and an FSM state tap.
interface fc_layer_engine_if;
   // Control handshake: start is taken on a rising edge only while busy=0;
   // busy stays high for the whole pass and done pulses for one cycle after the
   // last out_we. There is no back-pressure anywhere on this bus.
   logic        start;
   logic [10:0] n_in;
   logic [7:0]  n_out;
   logic [3:0]  shift;
   logic        relu_en;
   logic [10:0] in_addr;
   logic [7:0]  in_rdata;
   logic [17:0] w_addr;
   logic [7:0]  w_rdata;
   logic        out_we;
   logic [7:0]  out_addr;
   logic [7:0]  out_wdata;
   logic        busy;
   logic        done;
   logic [1:0]  dbg_state;

   modport master (
      input  start, n_in, n_out, shift, relu_en, in_rdata, w_rdata,
      output in_addr, w_addr, out_we, out_addr, out_wdata, busy, done, dbg_state
   );

   modport slave (
      output start, n_in, n_out, shift, relu_en, in_rdata, w_rdata,
      input  in_addr, w_addr, out_we, out_addr, out_wdata, busy, done, dbg_state
   );
endinterface

// File: rtl/fc_layer_engine.sv
// Fully connected layer engine: streams one activation vector against a row-major
// weight matrix, accumulates int8 dot products and writes requantised int8 results.
module fc_layer_engine #(
   parameter int IN_MAX  = 1152,
   parameter int OUT_MAX = 200,
   parameter int ACC_W   = 32
) (
   input  logic            clk,
   input  logic            reset,
   fc_layer_engine_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [10:0]             n_in_q;
   logic [7:0]              n_out_q;
   logic [3:0]              shift_q;
   logic                    relu_q;
   logic [10:0]             in_addr_q;
   logic [17:0]             w_addr_q;
   logic [7:0]              o_q;
   logic signed [ACC_W-1:0] acc;
   logic                    mac_v;
   logic                    done_q;

   logic [10:0]             n_in_clamp;
   logic [7:0]              n_out_clamp;
   logic                    degenerate;
   logic                    last_i;
   logic                    last_o;
   logic signed [15:0]      prod;
   logic signed [ACC_W-1:0] shifted;
   logic signed [ACC_W-1:0] rectified;
   logic [7:0]              q_data;

   always_comb begin
      n_in_clamp  = (bus.n_in > 11'(IN_MAX)) ? 11'(IN_MAX) : bus.n_in;
      n_out_clamp = (bus.n_out > 8'(OUT_MAX)) ? 8'(OUT_MAX) : bus.n_out;
      degenerate  = (n_in_clamp == 11'd0) || (n_out_clamp == 8'd0);
      last_i      = (in_addr_q == n_in_q - 11'd1);
      last_o      = (o_q == n_out_q - 8'd1);
      prod        = $signed(bus.in_rdata) * $signed(bus.w_rdata);
   end

   // Requantise: floor shift, optional ReLU, then saturate to int8.
   always_comb begin
      shifted   = acc >>> shift_q;
      rectified = shifted;
      if (relu_q && (shifted < 0)) begin
         rectified = '0;
      end
      if (rectified > 127) begin
         q_data = 8'h7f;
      end else if (rectified < -128) begin
         q_data = 8'h80;
      end else begin
         q_data = rectified[7:0];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = degenerate ? IDLE : RUN;
         RUN:     if (last_i) state_nxt = DRAIN;
         DRAIN:   state_nxt = WRITE;
         WRITE:   state_nxt = last_o ? IDLE : RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_in_q    <= '0;
         n_out_q   <= '0;
         shift_q   <= '0;
         relu_q    <= 1'b0;
         in_addr_q <= '0;
         w_addr_q  <= '0;
         o_q       <= '0;
         acc       <= '0;
         mac_v     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // Read data for a RUN-cycle address arrives one cycle later.
         mac_v  <= (state == RUN);
         done_q <= 1'b0;
         if (mac_v) begin
            acc <= acc + ACC_W'(prod);
         end
         case (state)
            IDLE: begin
               if (bus.start) begin
                  n_in_q  <= n_in_clamp;
                  n_out_q <= n_out_clamp;
                  shift_q <= bus.shift;
                  relu_q  <= bus.relu_en;
                  acc     <= '0;
                  if (degenerate) begin
                     done_q <= 1'b1;
                  end else begin
                     in_addr_q <= '0;
                     w_addr_q  <= '0;
                     o_q       <= '0;
                  end
               end
            end
            RUN: begin
               if (!last_i) begin
                  in_addr_q <= in_addr_q + 11'd1;
                  w_addr_q  <= w_addr_q + 18'd1;
               end
            end
            WRITE: begin
               acc <= '0;
               if (last_o) begin
                  done_q <= 1'b1;
               end else begin
                  o_q       <= o_q + 8'd1;
                  in_addr_q <= '0;
                  // Row-major layout: the next row starts right after this one.
                  w_addr_q  <= w_addr_q + 18'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_addr   = in_addr_q;
   assign bus.w_addr    = w_addr_q;
   assign bus.out_we    = (state == WRITE);
   assign bus.out_addr  = (state == WRITE) ? o_q : 8'd0;
   assign bus.out_wdata = (state == WRITE) ? q_data : 8'd0;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Self-checking bench for fc_layer_engine: memory models, a write scoreboard
// keyed by expected cycle, and one task per scenario.
module tb_fc_layer_engine;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   wr_cnt = 0;
   int   k_base = 0;

   logic [47:0] exp_q[$];
   logic [7:0]  act_mem [0:2047];
   logic [7:0]  w_mem   [0:262143];

   fc_layer_engine_if bus();

   fc_layer_engine dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      bus.in_rdata <= act_mem[bus.in_addr];
      bus.w_rdata  <= w_mem[bus.w_addr];
   end

   // Scoreboard: every write must match the head entry {cycle, addr, data}.
   always @(negedge clk) begin
      logic [47:0] e;
      if (reset === 1'b1 && bus.out_we === 1'b1) begin
         wr_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0d", cyc, bus.out_addr, bus.out_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({32'(cyc), bus.out_addr, bus.out_wdata} !== e) begin
               failures++;
               $display("FAIL write got cyc=%0d addr=%0d data=%0d exp cyc=%0d addr=%0d data=%0d",
                        cyc, bus.out_addr, $signed(bus.out_wdata), e[47:16], e[15:8], $signed(e[7:0]));
            end
         end
      end
   end

   task automatic push_expected(input int ni_raw, input int no_raw, input int sh, input bit relu, input int base);
      int ni, no;
      longint a, r;
      ni = (ni_raw > 1152) ? 1152 : ni_raw;
      no = (no_raw > 200) ? 200 : no_raw;
      if (ni == 0 || no == 0) return;
      for (int o = 0; o < no; o++) begin
         a = 0;
         for (int i = 0; i < ni; i++) begin
            a += longint'($signed(act_mem[i])) * longint'($signed(w_mem[o*ni + i]));
         end
         r = a >>> sh;
         if (relu && r < 0) r = 0;
         if (r > 127) r = 127;
         if (r < -128) r = -128;
         exp_q.push_back({32'(base - 1 + (o + 1) * (ni + 2)), 8'(o), 8'(r)});
      end
   endtask

   function automatic int exp_done(input int ni_raw, input int no_raw, input int base);
      int ni, no;
      ni = (ni_raw > 1152) ? 1152 : ni_raw;
      no = (no_raw > 200) ? 200 : no_raw;
      if (ni == 0 || no == 0) return base;
      return base + no * (ni + 2);
   endfunction

   // Driver: call at a negedge; returns #1 after the edge that samples start.
   task automatic kick(input int ni, input int no, input int sh, input bit relu, input bit push);
      bus.n_in    = 11'(ni);
      bus.n_out   = 8'(no);
      bus.shift   = 4'(sh);
      bus.relu_en = relu;
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      k_base    = cyc;
      bus.start = 1'b0;
      bus.n_in  = 11'($urandom_range(0, 2047));
      bus.n_out = 8'($urandom_range(0, 255));
      bus.shift = 4'($urandom_range(0, 15));
      if (push) push_expected(ni, no, sh, relu, k_base);
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.out_we} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags busy/done/we=%b exp 000", {bus.busy, bus.done, bus.out_we});
      end
      checks++;
      if ({bus.in_addr, bus.w_addr, bus.out_addr, bus.out_wdata} !== 45'd0) begin
         failures++;
         $display("FAIL reset_addr in=%0d w=%0d oa=%0d od=%0d exp 0", bus.in_addr, bus.w_addr, bus.out_addr, bus.out_wdata);
      end
      checks++;
      if (bus.dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_state got=%0d exp 0", bus.dbg_state);
      end
      reset = 1'b1;
   endtask

   task automatic load_basic;
      act_mem[0] = 8'd1; act_mem[1] = 8'd2; act_mem[2] = 8'd3;
      for (int i = 0; i < 3; i++) begin
         w_mem[i]     = 8'd1;
         w_mem[3 + i] = 8'hff;
      end
   endtask

   task automatic test_basic;
      bit ok;
      int ed;
      load_basic();
      @(negedge clk);
      kick(3, 2, 0, 1'b0, 1'b1);
      ed = exp_done(3, 2, k_base);
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy got=%b exp 1", bus.busy);
      end
      wait_done(50, ok);
      checks++;
      if (!ok || cyc !== ed || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_done ok=%0d cyc=%0d busy=%b exp cyc=%0d busy=0", ok, cyc, bus.busy, ed);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL basic_missing got_left=%0d exp 0", exp_q.size());
      end
   endtask

   task automatic test_relu_busy_start;
      bit ok;
      int ed, w0, dcnt;
      load_basic();
      w0 = wr_cnt;
      @(negedge clk);
      kick(3, 2, 0, 1'b1, 1'b1);
      ed = exp_done(3, 2, k_base);
      @(negedge clk);
      @(negedge clk);
      bus.n_in = 11'd3; bus.n_out = 8'd5; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(50, ok);
      checks++;
      if (!ok || cyc !== ed) begin
         failures++;
         $display("FAIL relu_done ok=%0d cyc=%0d exp %0d", ok, cyc, ed);
      end
      dcnt = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (bus.done === 1'b1) dcnt++;
      end
      checks++;
      if (dcnt != 0 || wr_cnt - w0 != 2 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL relu_ignored_start extra_done=%0d writes=%0d left=%0d exp 0/2/0", dcnt, wr_cnt - w0, exp_q.size());
      end
   endtask

   task automatic test_saturation;
      bit ok;
      int ed;
      int sh_tab [3] = '{0, 9, 0};
      logic [7:0] w_tab [3] = '{8'd127, 8'd127, 8'h81};
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 4; i++) begin
            act_mem[i] = 8'd127;
            w_mem[i]   = w_tab[s];
         end
         @(negedge clk);
         kick(4, 1, sh_tab[s], 1'b0, 1'b1);
         ed = exp_done(4, 1, k_base);
         wait_done(30, ok);
         checks++;
         if (!ok || cyc !== ed || exp_q.size() != 0) begin
            failures++;
            $display("FAIL sat_%0d ok=%0d cyc=%0d left=%0d exp cyc=%0d left=0", s, ok, cyc, exp_q.size(), ed);
         end
      end
   endtask

   task automatic test_floor;
      bit ok;
      int ed;
      for (int i = 0; i < 3; i++) begin
         act_mem[i]   = 8'd1;
         w_mem[i]     = 8'hff;
         w_mem[3 + i] = 8'd1;
      end
      @(negedge clk);
      kick(3, 2, 1, 1'b0, 1'b1);
      ed = exp_done(3, 2, k_base);
      wait_done(40, ok);
      checks++;
      if (!ok || cyc !== ed || exp_q.size() != 0) begin
         failures++;
         $display("FAIL floor ok=%0d cyc=%0d left=%0d exp cyc=%0d left=0", ok, cyc, exp_q.size(), ed);
      end
   endtask

   task automatic test_degenerate;
      bit ok;
      int w0;
      int ni_tab [2] = '{5, 0};
      int no_tab [2] = '{0, 3};
      for (int s = 0; s < 2; s++) begin
         w0 = wr_cnt;
         @(negedge clk);
         kick(ni_tab[s], no_tab[s], 0, 1'b0, 1'b1);
         wait_done(5, ok);
         checks++;
         if (!ok || cyc !== k_base || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL degen_%0d_done ok=%0d cyc=%0d busy=%b exp cyc=%0d busy=0", s, ok, cyc, bus.busy, k_base);
         end
         repeat (10) @(negedge clk);
         checks++;
         if (wr_cnt != w0) begin
            failures++;
            $display("FAIL degen_%0d_writes got=%0d exp 0", s, wr_cnt - w0);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int ed, ni, no;
      for (int i = 0; i < 64; i++) act_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 512; i++) w_mem[i] = 8'($urandom_range(0, 255));
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
         ni = $urandom_range(1, 20);
         no = $urandom_range(1, 5);
         kick(ni, no, $urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'b1);
         ed = exp_done(ni, no, k_base);
         wait_done(200, ok);
         checks++;
         if (!ok || cyc !== ed) begin
            failures++;
            $display("FAIL b2b_%0d_done ok=%0d cyc=%0d exp %0d", p, ok, cyc, ed);
         end
      end
      wait_done(3, ok);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_missing left=%0d exp 0", exp_q.size());
      end
   endtask

   task automatic test_clamp;
      bit ok;
      int ed;
      for (int i = 0; i < 2048; i++) act_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 2400; i++) w_mem[i] = 8'($urandom_range(0, 255));
      @(negedge clk);
      kick(2000, 2, 7, 1'b0, 1'b1);
      ed = exp_done(2000, 2, k_base);
      wait_done(3000, ok);
      checks++;
      if (!ok || cyc !== ed || exp_q.size() != 0) begin
         failures++;
         $display("FAIL clamp ok=%0d cyc=%0d left=%0d exp cyc=%0d left=0", ok, cyc, exp_q.size(), ed);
      end
   endtask

   task automatic test_reset_mid;
      int w0, dcnt;
      @(negedge clk);
      kick(1152, 200, 0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.out_we, bus.in_addr, bus.w_addr, bus.out_addr, bus.out_wdata, bus.dbg_state} !== 50'd0) begin
         failures++;
         $display("FAIL midreset_outputs busy=%b in=%0d w=%0d st=%0d exp all 0", bus.busy, bus.in_addr, bus.w_addr, bus.dbg_state);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      w0 = wr_cnt;
      dcnt = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
      end
      checks++;
      if (wr_cnt != w0 || dcnt != 0) begin
         failures++;
         $display("FAIL midreset_quiet writes=%0d active=%0d exp 0/0", wr_cnt - w0, dcnt);
      end
      test_basic();
   endtask

   initial begin
      bus.start = 1'b0; bus.n_in = '0; bus.n_out = '0; bus.shift = '0; bus.relu_en = 1'b0;
      repeat (3) @(posedge clk);
      test_reset();
      test_basic();
      test_relu_busy_start();
      test_saturation();
      test_floor();
      test_degenerate();
      test_back_to_back();
      test_clamp();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
